mem_arbiter: RTL and testbench

- Shares the single memory port between three requesters:
  - the page-table walker (translater memory interface),
  - data load/store,
  - instruction fetch.
- Runs one transaction at a time, with fixed priority and a starvation guard.
- Sits between the core/translater and the memory system.
- Routes read data and the completion pulse back to the requester that owns the current transaction.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_select.sv | 62 ++++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter (walker / data / fetch).
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PTW  = 2'd1,
        OWN_DMEM = 2'd2,
        OWN_IMEM = 2'd3
    } owner_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// Grant selection: ptw first, then dmem/imem by fixed priority with a fetch
// starvation guard, or round-robin when MEM_ARBITER_RR_EN is defined.
module arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   ptw_req,
    input  logic   dmem_req,
    input  logic   imem_req,
    input  logic   grant_en,
    output owner_t grant
);

`ifdef MEM_ARBITER_RR_EN
    logic prefer_imem;

    always_comb begin
        grant = OWN_NONE;
        if (ptw_req)                   grant = OWN_PTW;
        else if (dmem_req && imem_req) grant = prefer_imem ? OWN_IMEM : OWN_DMEM;
        else if (dmem_req)             grant = OWN_DMEM;
        else if (imem_req)             grant = OWN_IMEM;
    end

    // Only a contested dmem/imem grant moves the preference.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prefer_imem <= 1'b0;
        else if (grant_en && !ptw_req && dmem_req && imem_req)
            prefer_imem <= (grant == OWN_DMEM);
    end
`else
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        grant = OWN_NONE;
        if (ptw_req)                         grant = OWN_PTW;
        else if (dmem_req && !(starved && imem_req)) grant = OWN_DMEM;
        else if (imem_req)                   grant = OWN_IMEM;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (grant_en) begin
            if (grant == OWN_IMEM)
                starve_cnt <= '0;
            else if (imem_req && !starved)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one transaction at a time, IDLE -> ISSUE -> WAIT.
// Optional round-robin dmem/imem arbitration via MEM_ARBITER_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ptw_enable,
    input  logic [ADDR_W-1:0] ptw_addr,
    output logic [DATA_W-1:0] ptw_data,
    output logic              ptw_valid,
    input  logic              dmem_enable,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_valid,
    input  logic              imem_enable,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_rdata,
    output logic              imem_valid,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    state_t            state, state_nxt;
    owner_t            owner, grant;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic              write_q, sel_write;
    logic [DATA_W-1:0] wdata_q, sel_wdata;
    logic [DATA_W-1:0] ptw_rdata_q, dmem_rdata_q, imem_rdata_q;
    logic              grant_en, done;

    assign grant_en = (state == S_IDLE) && (ptw_enable || dmem_enable || imem_enable);
    assign done     = (state == S_WAIT) && mem_rvalid;

    arb_select #(.STARVE_MAX(STARVE_MAX)) u_select (
        .clk      (clk),
        .reset    (reset),
        .ptw_req  (ptw_enable),
        .dmem_req (dmem_enable),
        .imem_req (imem_enable),
        .grant_en (grant_en),
        .grant    (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_en)   state_nxt = S_ISSUE;
            S_ISSUE: if (mem_ready)  state_nxt = S_WAIT;
            S_WAIT:  if (mem_rvalid) state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Read data is forwarded in the completion cycle; otherwise each port holds.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ptw_valid  = 1'b0;
        dmem_valid = 1'b0;
        imem_valid = 1'b0;
        ptw_data   = ptw_rdata_q;
        dmem_rdata = dmem_rdata_q;
        imem_rdata = imem_rdata_q;
        case (state)
            S_ISSUE: begin
                mem_req   = 1'b1;
                mem_write = write_q;
            end
            S_WAIT: if (mem_rvalid) begin
                case (owner)
                    OWN_PTW:  begin ptw_valid  = 1'b1; ptw_data   = mem_rdata; end
                    OWN_DMEM: begin dmem_valid = 1'b1; dmem_rdata = mem_rdata; end
                    OWN_IMEM: begin imem_valid = 1'b1; imem_rdata = mem_rdata; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        sel_addr  = imem_addr;
        sel_write = 1'b0;
        sel_wdata = '0;
        case (grant)
            OWN_PTW:  sel_addr = ptw_addr;
            OWN_DMEM: begin
                sel_addr  = dmem_addr;
                sel_write = dmem_write;
                sel_wdata = dmem_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner        <= OWN_NONE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            ptw_rdata_q  <= '0;
            dmem_rdata_q <= '0;
            imem_rdata_q <= '0;
        end else begin
            if (grant_en) begin
                owner   <= grant;
                addr_q  <= sel_addr;
                write_q <= sel_write;
                wdata_q <= sel_wdata;
            end
            if (done) begin
                owner <= OWN_NONE;
                case (owner)
                    OWN_PTW:  ptw_rdata_q  <= mem_rdata;
                    OWN_DMEM: dmem_rdata_q <= mem_rdata;
                    OWN_IMEM: imem_rdata_q <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, directed
// requester queues, a simple memory responder; honours MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

    localparam int SM = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ptw_enable, dmem_enable, dmem_write, imem_enable;
    logic [31:0] ptw_addr, dmem_addr, dmem_wdata, imem_addr;
    logic [31:0] ptw_data, dmem_rdata, imem_rdata;
    logic        ptw_valid, dmem_valid, imem_valid;
    logic        mem_req, mem_write, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .ptw_enable(ptw_enable), .ptw_addr(ptw_addr), .ptw_data(ptw_data), .ptw_valid(ptw_valid),
        .dmem_enable(dmem_enable), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
        .imem_enable(imem_enable), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] wd; } req_t;
    typedef struct { int own; logic [31:0] data; } done_t;

    req_t  pq[$], dq[$], iq[$];
    done_t dlog[$];
    req_t  ilog[$];
    int    req_cycles;
    int    n_pass = 0, n_tot = 0;

    // Responder knobs
    int rdy_dly = 0, rv_dly = 0;
    bit stray = 0;
    int rphase = 0, rcnt = 0;
    logic [31:0] raddr;

    // Model state
    bit          m_busy, m_acc;
    int          m_own, m_starve;
    bit          m_rr_imem;
    logic [31:0] m_addr, m_wd;
    logic        m_wr;
    logic [31:0] m_last [1:3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input bit p, input bit d, input bit i);
        if (p) return 1;
`ifdef MEM_ARBITER_RR_EN
        if (d && i) return m_rr_imem ? 3 : 2;
`else
        if (d && i && m_starve == SM) return 3;
`endif
        if (d) return 2;
        if (i) return 3;
        return 0;
    endfunction

    function automatic int own_at(input int idx);
        if (idx < dlog.size()) return dlog[idx].own;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_own = 0; m_starve = 0; m_rr_imem = 0;
        for (int k = 1; k <= 3; k++) m_last[k] = '0;
    endtask

    // Memory: ready after rdy_dly request cycles, rvalid rv_dly cycles into WAIT.
    initial begin
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 32'hBAD0BAD0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 0; mem_rvalid = 0; mem_rdata = 32'hBAD0BAD0;
            if (!reset) begin rphase = 0; rcnt = 0; end
            else if (rphase == 0) begin
                if (stray) mem_rvalid = 1;
                if (mem_req) begin
                    if (rcnt >= rdy_dly) begin mem_ready = 1; raddr = mem_addr; rphase = 1; rcnt = 0; end
                    else rcnt++;
                end
            end else begin
                if (rcnt >= rv_dly) begin
                    mem_rvalid = 1;
                    mem_rdata  = (raddr == 32'h1000) ? 32'hDEADBEEF : ~raddr;
                    rphase = 0; rcnt = 0;
                end else rcnt++;
            end
        end
    end

    // Compare, then requester agents, then model advance for the next edge.
    always @(negedge clk) begin : cmp
        bit          exp_req, fin;
        logic [31:0] er;
        if (!reset) begin
            chk("rst_mem_req", 32'(mem_req), 0);
            chk("rst_valids", {29'd0, ptw_valid, dmem_valid, imem_valid}, 0);
            chk("rst_rdata", ptw_data | dmem_rdata | imem_rdata, 0);
            model_reset();
        end else begin
            exp_req = m_busy && !m_acc;
            fin     = m_busy && m_acc && mem_rvalid;
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_write", 32'(mem_write), 32'(m_wr));
                chk("mem_wdata", mem_wdata, m_wd);
            end
            chk("ptw_valid", 32'(ptw_valid), 32'(fin && m_own == 1));
            chk("dmem_valid", 32'(dmem_valid), 32'(fin && m_own == 2));
            chk("imem_valid", 32'(imem_valid), 32'(fin && m_own == 3));
            er = (fin && m_own == 1) ? mem_rdata : m_last[1]; chk("ptw_data", ptw_data, er);
            er = (fin && m_own == 2) ? mem_rdata : m_last[2]; chk("dmem_rdata", dmem_rdata, er);
            er = (fin && m_own == 3) ? mem_rdata : m_last[3]; chk("imem_rdata", imem_rdata, er);
            if (ptw_valid)  dlog.push_back('{1, ptw_data});
            if (dmem_valid) dlog.push_back('{2, dmem_rdata});
            if (imem_valid) dlog.push_back('{3, imem_rdata});
            if (mem_req) req_cycles++;
            if (mem_req && mem_ready) ilog.push_back('{mem_addr, mem_write, mem_wdata});
        end

        if (ptw_valid && pq.size() > 0)  pq.delete(0);
        if (dmem_valid && dq.size() > 0) dq.delete(0);
        if (imem_valid && iq.size() > 0) iq.delete(0);
        ptw_enable  = pq.size() > 0; ptw_addr = ptw_enable ? pq[0].addr : '0;
        dmem_enable = dq.size() > 0;
        dmem_addr   = dmem_enable ? dq[0].addr : '0;
        dmem_write  = dmem_enable ? dq[0].wr : 1'b0;
        dmem_wdata  = dmem_enable ? dq[0].wd : '0;
        imem_enable = iq.size() > 0; imem_addr = imem_enable ? iq[0].addr : '0;

        if (reset) begin
            if (!m_busy) begin
                if (ptw_enable || dmem_enable || imem_enable) begin
                    m_own = pick(ptw_enable, dmem_enable, imem_enable);
                    if (m_own == 3) m_starve = 0;
                    else if (imem_enable && m_starve < SM) m_starve++;
                    if (dmem_enable && imem_enable && m_own != 1) m_rr_imem = (m_own == 2);
                    m_busy = 1; m_acc = 0;
                    m_wr = 0; m_wd = '0;
                    case (m_own)
                        1: m_addr = ptw_addr;
                        2: begin m_addr = dmem_addr; m_wr = dmem_write; m_wd = dmem_wdata; end
                        default: m_addr = imem_addr;
                    endcase
                end
            end else if (!m_acc) begin
                if (mem_ready) m_acc = 1;
            end else if (mem_rvalid) begin
                m_busy = 0;
                m_last[m_own] = mem_rdata;
            end
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while ((pq.size() || dq.size() || iq.size() || m_busy) && n < 400) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 400) begin
            n_tot++;
            $display("FAIL %s: timeout, still pending after %0d cycles", name, n);
        end
    endtask

    task automatic clear_logs();
        dlog.delete(); ilog.delete(); req_cycles = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1;
    endtask

    initial begin
        int n;
        reset = 0;
        model_reset();
        ptw_enable = 0; dmem_enable = 0; imem_enable = 0; dmem_write = 0;
        ptw_addr = 0; dmem_addr = 0; dmem_wdata = 0; imem_addr = 0;
        @(posedge clk); #1;
        chk("init_mem_req", 32'(mem_req), 0);
        chk("init_valids", {29'd0, ptw_valid, dmem_valid, imem_valid}, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1;

        // 1: fetch only, rvalid two cycles after ready
        clear_logs(); rv_dly = 1;
        iq.push_back('{32'h1000, 1'b0, 32'h0});
        wait_done("t1");
        chk("t1_count", dlog.size(), 1);
        chk("t1_owner", own_at(0), 3);
        if (dlog.size() > 0) chk("t1_rdata", dlog[0].data, 32'hDEADBEEF);
        if (ilog.size() > 0) begin
            chk("t1_addr", ilog[0].addr, 32'h1000);
            chk("t1_write", 32'(ilog[0].wr), 0);
        end

        // 2: all three together
        clear_logs(); rv_dly = 0;
        pq.push_back('{32'h8000_0004, 1'b0, 32'h0});
        dq.push_back('{32'h3000, 1'b0, 32'h0});
        iq.push_back('{32'h1004, 1'b0, 32'h0});
        wait_done("t2");
        chk("t2_order0", own_at(0), 1);
        chk("t2_order1", own_at(1), 2);
        chk("t2_order2", own_at(2), 3);
        if (ilog.size() > 0) chk("t2_ptw_addr", ilog[0].addr, 32'h8000_0004);

        // 3: store
        clear_logs();
        dq.push_back('{32'h2000, 1'b1, 32'h12345678});
        wait_done("t3");
        chk("t3_owner", own_at(0), 2);
        if (ilog.size() > 0) begin
            chk("t3_addr", ilog[0].addr, 32'h2000);
            chk("t3_write", 32'(ilog[0].wr), 1);
            chk("t3_wdata", ilog[0].wd, 32'h12345678);
        end

        // 4: ready held low 5 cycles, stray rvalids outside WAIT
        clear_logs(); rdy_dly = 5; stray = 1;
        iq.push_back('{32'h1008, 1'b0, 32'h0});
        wait_done("t4");
        rdy_dly = 0; stray = 0;
        chk("t4_req_cycles", req_cycles, 6);
        chk("t4_count", dlog.size(), 1);
        if (dlog.size() > 0) chk("t4_rdata", dlog[0].data, ~32'h1008);

        // 5: reset during WAIT with rvalid present
        clear_logs(); rv_dly = 0;
        dq.push_back('{32'h4000, 1'b0, 32'h0});
        n = 0;
        do begin @(negedge clk); n++; end while (!(mem_req && mem_ready) && n < 50);
        if (n >= 50) begin n_tot++; $display("FAIL t5_issue: no accepted request"); end
        @(posedge clk); #2 reset = 0;
        #1;
        chk("t5_rst_req", 32'(mem_req), 0);
        chk("t5_rst_dvalid", 32'(dmem_valid), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1;
        wait_done("t5");
        chk("t5_count", dlog.size(), 1);
        chk("t5_owner", own_at(0), 2);
        if (dlog.size() > 0) chk("t5_rdata", dlog[0].data, 32'hFFFFBFFF);

        // 6: dmem and imem held continuously
        do_reset();
        clear_logs();
        for (int k = 0; k < 10; k++) dq.push_back('{32'h5000 + 32'(4 * k), 1'b0, 32'h0});
        iq.push_back('{32'h6000, 1'b0, 32'h0});
        iq.push_back('{32'h6004, 1'b0, 32'h0});
        wait_done("t6");
        chk("t6_count", dlog.size(), 12);
`ifdef MEM_ARBITER_RR_EN
        chk("t6_rr0", own_at(0), 2);
        chk("t6_rr1", own_at(1), 3);
        chk("t6_rr2", own_at(2), 2);
        chk("t6_rr3", own_at(3), 3);
`else
        chk("t6_d8", own_at(7), 2);
        chk("t6_i9", own_at(8), 3);
        chk("t6_d10", own_at(9), 2);
        chk("t6_d11", own_at(10), 2);
        chk("t6_i12", own_at(11), 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
